pw_pattern_match: RTL and testbench
===================================

PW_PATTERN_MATCH -- requirements
Module: pw_pattern_match

Interface
REQ-001 Parameter pPATTERN_BYTES, default 8, sets the number of bytes in the pattern/shift window.
REQ-002 Parameter pCOUNT_WIDTH, default 16, sets the width of the match counter.
REQ-003 Port fe_clk, input, 1: the single clock for the block; all other ports are synchronous to it.
REQ-004 Port reset_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port I_data, input, 8: front-end USB byte.
REQ-006 Port I_data_valid, input, 1: I_data is valid this cycle.
REQ-007 Port I_pattern, input, 8*pPATTERN_BYTES: pattern; bits [7:0] are the most recent byte.
REQ-008 Port I_mask, input, 8*pPATTERN_BYTES: per-bit compare mask, 1 = compare; same byte order as I_pattern.
REQ-009 Port I_pattern_bytes, input, 4: pattern length, 1..pPATTERN_BYTES.
REQ-010 Port I_arm, input, 1: single-cycle arm request.
REQ-011 Port I_disarm, input, 1: single-cycle disarm request.
REQ-012 Port I_auto_rearm, input, 1: rearm automatically after a match.
REQ-013 Port O_match, output, 1: single-cycle match pulse, consumed by pw_trigger as I_match.
REQ-014 Port O_armed, output, 1: high when in state ARMED.
REQ-015 Port O_match_count, output, pCOUNT_WIDTH: saturating count of matches since the last arm.

Function
REQ-016 Shift window: on each I_data_valid cycle, the window shifts left by 8 bits and I_data enters at bits [7:0]; the window holds otherwise, in every state.
REQ-017 Fill counter: cleared on arm, incremented on each valid byte while ARMED, saturating at pPATTERN_BYTES.
REQ-018 Compare: true when, for bytes 0..I_pattern_bytes-1 of the updated window, (window AND mask) equals (pattern AND mask); bytes at or above I_pattern_bytes are ignored.
REQ-019 The compare shall use the window value that includes the current I_data.
REQ-020 Qualification: a match requires state ARMED, I_data_valid, compare true, and fill count after the update of at least I_pattern_bytes.
REQ-021 Latency: O_match is asserted on the cycle after the qualifying I_data_valid cycle, is registered, and is high for exactly one cycle.
REQ-022 I_pattern_bytes equal to 0 or greater than pPATTERN_BYTES disables matching; the block never asserts O_match.
REQ-023 A mask of all zeros over the active length matches on every valid byte once the fill requirement is met.
REQ-024 State machine states: IDLE, ARMED, HOLD.
  - IDLE -> ARMED on I_arm; this clears the fill counter and O_match_count.
  - ARMED -> HOLD on a match when I_auto_rearm is 0.
  - ARMED -> ARMED on a match when I_auto_rearm is 1; the fill counter is cleared, so patterns do not overlap.
  - HOLD -> ARMED on I_arm.
  - Any state -> IDLE on I_disarm.
REQ-025 Simultaneous events: I_disarm has priority over I_arm. I_arm has priority over a same-cycle match: no match is reported for that byte, and the byte is counted as fill byte 1.
REQ-026 I_arm while already ARMED restarts the fill counter and clears O_match_count.
REQ-027 O_match_count increments on each O_match and saturates at all-ones.
REQ-028 I_pattern, I_mask and I_pattern_bytes are quasi-static; they shall be changed only while IDLE.

Reset
REQ-029 Assertion of reset_n low immediately clears state to IDLE, window to 0, fill counter to 0, O_match to 0, O_armed to 0 and O_match_count to 0.
REQ-030 Reset asserted mid-pattern discards partial state; after release, matching requires a new I_arm.
REQ-031 Reset release is synchronised to fe_clk internally before it is used by the state machine.

Structure
REQ-032 The state encodings and the pPATTERN_BYTES and pCOUNT_WIDTH defaults belong in the shared pw package.
REQ-033 The masked per-byte comparator is one sub-module, pw_masked_compare: combinational, one instance.
REQ-034 Only flops and registers plus pw_masked_compare; no RAM.

Verification
REQ-035 Exact match: len=3, pattern 0xA5C3_0F, mask all ones, arm, then bytes A5,C3,0F -> O_match high one cycle after the 0F byte; count=1; state HOLD.
REQ-036 Masked match: len=2, pattern 0x12_34, mask 0xFF_F0, bytes 12,3B -> match; bytes 13,34 -> no match.
REQ-037 Fill guard: len=4, all-zero mask, arm, then 3 valid bytes -> no match; 4th byte -> match.
REQ-038 Auto-rearm: len=1, pattern 0x55, auto_rearm=1, bytes 55,55,AA,55 -> three O_match pulses; count=3; O_armed stays high.
REQ-039 Collisions:
  - I_arm on the same cycle as a completing byte -> no pulse.
  - I_disarm together with I_arm -> IDLE.
REQ-040 Async reset: assert reset_n low between the 2nd and 3rd bytes of a len=3 match -> all outputs 0 immediately; no match after release until a new arm.

Source files
------------

// File: rtl/pw_pattern_match_pkg.sv
// Shared definitions for the pw pattern matcher: FSM state encoding and
// parameter defaults used by the top and its comparator.
package pw_pattern_match_pkg;

   localparam int PW_PATTERN_BYTES_DEF = 8;
   localparam int PW_COUNT_WIDTH_DEF   = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_HOLD  = 2'd2
   } pw_state_e;

endpackage

// File: rtl/pw_pattern_match_compare.sv
// Masked per-byte comparator: only the lowest I_len bytes take part, and an
// out-of-range length never reports equality.
module pw_masked_compare
   import pw_pattern_match_pkg::*;
#(
   parameter int pPATTERN_BYTES = PW_PATTERN_BYTES_DEF
) (
   input  logic [8*pPATTERN_BYTES-1:0] I_window,
   input  logic [8*pPATTERN_BYTES-1:0] I_pattern,
   input  logic [8*pPATTERN_BYTES-1:0] I_mask,
   input  logic [3:0]                  I_len,
   output logic                        O_equal
);

   always_comb begin
      O_equal = (I_len != 4'd0) && (int'(I_len) <= pPATTERN_BYTES);
      for (int i = 0; i < pPATTERN_BYTES; i++) begin
         if (i < int'(I_len)) begin
            if (((I_window[8*i +: 8] ^ I_pattern[8*i +: 8]) & I_mask[8*i +: 8]) != 8'h00)
               O_equal = 1'b0;
         end
      end
   end

endmodule

// File: rtl/pw_pattern_match.sv
// Byte-stream pattern matcher: shift window, masked compare against a
// programmable pattern, arm/hold FSM and saturating match counter.
module pw_pattern_match
   import pw_pattern_match_pkg::*;
#(
   parameter int pPATTERN_BYTES = PW_PATTERN_BYTES_DEF,
   parameter int pCOUNT_WIDTH   = PW_COUNT_WIDTH_DEF
) (
   input  logic                        fe_clk,
   input  logic                        reset_n,
   input  logic [7:0]                  I_data,
   input  logic                        I_data_valid,
   input  logic [8*pPATTERN_BYTES-1:0] I_pattern,
   input  logic [8*pPATTERN_BYTES-1:0] I_mask,
   input  logic [3:0]                  I_pattern_bytes,
   input  logic                        I_arm,
   input  logic                        I_disarm,
   input  logic                        I_auto_rearm,
   output logic                        O_match,
   output logic                        O_armed,
   output logic [pCOUNT_WIDTH-1:0]     O_match_count
);

   localparam int WIN_W  = 8 * pPATTERN_BYTES;
   localparam int FILL_W = $clog2(pPATTERN_BYTES + 1);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(pPATTERN_BYTES);

   logic [1:0]              r_rst_sync;
   logic                    w_rst_n;
   pw_state_e               r_state;
   logic [WIN_W-1:0]        r_window;
   logic [WIN_W-1:0]        w_window_next;
   logic [FILL_W-1:0]       r_fill;
   logic [FILL_W-1:0]       w_fill_inc;
   logic                    w_equal;
   logic                    w_hit;
   logic                    r_match;
   logic                    r_armed;
   logic [pCOUNT_WIDTH-1:0] r_count;

   // Assertion passes straight through; release reaches the core two edges later.
   always_ff @(posedge fe_clk or negedge reset_n) begin
      if (!reset_n) r_rst_sync <= 2'b00;
      else          r_rst_sync <= {r_rst_sync[0], 1'b1};
   end
   assign w_rst_n = r_rst_sync[1];

   assign w_window_next = (r_window << 8) | WIN_W'(I_data);
   assign w_fill_inc    = (r_fill == FILL_MAX) ? r_fill : r_fill + 1'b1;

   pw_masked_compare #(
      .pPATTERN_BYTES(pPATTERN_BYTES)
   ) u_cmp (
      .I_window (w_window_next),
      .I_pattern(I_pattern),
      .I_mask   (I_mask),
      .I_len    (I_pattern_bytes),
      .O_equal  (w_equal)
   );

   assign w_hit = (r_state == ST_ARMED) && I_data_valid && w_equal &&
                  (int'(w_fill_inc) >= int'(I_pattern_bytes));

   always_ff @(posedge fe_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state  <= ST_IDLE;
         r_window <= '0;
         r_fill   <= '0;
         r_match  <= 1'b0;
         r_armed  <= 1'b0;
         r_count  <= '0;
      end else begin
         r_match <= 1'b0;
         if (I_data_valid) r_window <= w_window_next;
         if (I_disarm) begin
            r_state <= ST_IDLE;
            r_armed <= 1'b0;
         end else if (I_arm) begin
            // An arm always wins over a completing byte, which becomes fill byte 1.
            r_state <= ST_ARMED;
            r_armed <= 1'b1;
            r_fill  <= I_data_valid ? FILL_W'(1) : '0;
            r_count <= '0;
         end else if (r_state == ST_ARMED && I_data_valid) begin
            if (w_hit) begin
               r_match <= 1'b1;
               r_fill  <= '0;
               if (r_count != '1) r_count <= r_count + 1'b1;
               if (!I_auto_rearm) begin
                  r_state <= ST_HOLD;
                  r_armed <= 1'b0;
               end
            end else begin
               r_fill <= w_fill_inc;
            end
         end
      end
   end

   assign O_match       = r_match;
   assign O_armed       = r_armed;
   assign O_match_count = r_count;

endmodule

// File: tb/tb_pw_pattern_match.sv
// Bench for pw_pattern_match: directed scenarios plus randomized traffic,
// all checked against a byte-history reference model.
module tb_pw_pattern_match;

   localparam int NB   = 8;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic            fe_clk = 1'b0;
   logic            reset_n = 1'b0;
   logic [7:0]      I_data = 8'h00;
   logic            I_data_valid = 1'b0;
   logic [8*NB-1:0] I_pattern = '0;
   logic [8*NB-1:0] I_mask = '0;
   logic [3:0]      I_pattern_bytes = 4'd0;
   logic            I_arm = 1'b0;
   logic            I_disarm = 1'b0;
   logic            I_auto_rearm = 1'b0;
   logic            O_match;
   logic            O_armed;
   logic [CW-1:0]   O_match_count;

   pw_pattern_match #(
      .pPATTERN_BYTES(NB),
      .pCOUNT_WIDTH  (CW)
   ) dut (
      .fe_clk         (fe_clk),
      .reset_n        (reset_n),
      .I_data         (I_data),
      .I_data_valid   (I_data_valid),
      .I_pattern      (I_pattern),
      .I_mask         (I_mask),
      .I_pattern_bytes(I_pattern_bytes),
      .I_arm          (I_arm),
      .I_disarm       (I_disarm),
      .I_auto_rearm   (I_auto_rearm),
      .O_match        (O_match),
      .O_armed        (O_armed),
      .O_match_count  (O_match_count)
   );

   always #5 fe_clk = ~fe_clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Reference model: m_hist[0] is the newest byte; 0=IDLE 1=ARMED 2=HOLD.
   logic [7:0] m_hist[NB];
   int         m_state, m_fill, m_count, m_hold;
   bit         m_match;

   task automatic model_reset();
      for (int k = 0; k < NB; k++) m_hist[k] = 8'h00;
      m_state = 0; m_fill = 0; m_count = 0; m_match = 1'b0;
   endtask

   function automatic bit model_equal();
      int len = int'(I_pattern_bytes);
      if (len < 1 || len > NB) return 1'b0;
      for (int k = 0; k < len; k++)
         if ((m_hist[k] & I_mask[8*k +: 8]) != (I_pattern[8*k +: 8] & I_mask[8*k +: 8]))
            return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_edge();
      int fup;
      m_match = 1'b0;
      if (m_hold > 0) begin
         m_hold--;
         return;
      end
      if (I_data_valid) begin
         for (int k = NB - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
         m_hist[0] = I_data;
      end
      if (I_disarm) m_state = 0;
      else if (I_arm) begin
         m_state = 1;
         m_fill  = I_data_valid ? 1 : 0;
         m_count = 0;
      end else if (m_state == 1 && I_data_valid) begin
         fup = (m_fill + 1 > NB) ? NB : m_fill + 1;
         if (model_equal() && fup >= int'(I_pattern_bytes)) begin
            m_match = 1'b1;
            if (m_count < CMAX) m_count++;
            m_fill = 0;
            if (!I_auto_rearm) m_state = 2;
         end else begin
            m_fill = fup;
         end
      end
   endtask

   task automatic cycle(input bit vld, input logic [7:0] d, input bit arm, input bit dis, input string tag);
      I_data_valid = vld; I_data = d; I_arm = arm; I_disarm = dis;
      model_edge();
      @(posedge fe_clk);
      #1;
      check_eq({tag, ".match"}, 32'(O_match), 32'(m_match));
      check_eq({tag, ".armed"}, 32'(O_armed), 32'(m_state == 1));
      check_eq({tag, ".count"}, 32'(O_match_count), 32'(m_count));
      I_data_valid = 1'b0; I_arm = 1'b0; I_disarm = 1'b0;
   endtask

   task automatic cfg(input logic [8*NB-1:0] pat, input logic [8*NB-1:0] msk, input int len, input bit auto_r);
      cycle(0, 8'h00, 0, 1, "cfg.dis");
      I_pattern = pat; I_mask = msk; I_pattern_bytes = 4'(len); I_auto_rearm = auto_r;
   endtask

   task automatic reset_release();
      reset_n = 1'b1;
      m_hold  = 2;
   endtask

   task automatic outputs_zero(input string tag);
      check_eq({tag, ".match0"}, 32'(O_match), 32'd0);
      check_eq({tag, ".armed0"}, 32'(O_armed), 32'd0);
      check_eq({tag, ".count0"}, 32'(O_match_count), 32'd0);
   endtask

   initial begin
      logic [7:0] d;
      int len, cur;
      model_reset();
      m_hold = 1 << 30;
      #2;
      outputs_zero("por");
      cycle(0, 8'h00, 0, 0, "por.hold");
      reset_release();
      cycle(0, 8'h00, 1, 0, "sync.arm_dropped");
      check_eq("sync.not_armed", 32'(O_armed), 32'd0);
      cycle(0, 8'h00, 0, 0, "sync.idle");

      // Exact match, length 3.
      cfg(64'hA5C30F, '1, 3, 0);
      cycle(0, 8'h00, 1, 0, "ex.arm");
      cycle(1, 8'hA5, 0, 0, "ex.b0");
      cycle(1, 8'hC3, 0, 0, "ex.b1");
      cycle(1, 8'h0F, 0, 0, "ex.b2");
      check_eq("ex.pulse", 32'(O_match), 32'd1);
      check_eq("ex.count1", 32'(O_match_count), 32'd1);
      check_eq("ex.hold", 32'(O_armed), 32'd0);
      cycle(0, 8'h00, 0, 0, "ex.after");
      check_eq("ex.one_cycle", 32'(O_match), 32'd0);

      // Masked match and masked miss.
      cfg(64'h1234, 64'hFFF0, 2, 0);
      cycle(0, 8'h00, 1, 0, "mk.arm");
      cycle(1, 8'h12, 0, 0, "mk.b0");
      cycle(1, 8'h3B, 0, 0, "mk.b1");
      check_eq("mk.hit", 32'(O_match), 32'd1);
      cycle(0, 8'h00, 1, 0, "mk.rearm");
      cycle(1, 8'h13, 0, 0, "mk.c0");
      cycle(1, 8'h34, 0, 0, "mk.c1");
      check_eq("mk.miss", 32'(O_match), 32'd0);
      check_eq("mk.still_armed", 32'(O_armed), 32'd1);

      // Fill guard with an all-zero mask.
      cfg(64'h0, 64'h0, 4, 0);
      cycle(0, 8'h00, 1, 0, "fg.arm");
      for (int i = 0; i < 3; i++) begin
         cycle(1, 8'($urandom), 0, 0, "fg.b");
         check_eq("fg.early", 32'(O_match), 32'd0);
      end
      cycle(1, 8'($urandom), 0, 0, "fg.b3");
      check_eq("fg.hit", 32'(O_match), 32'd1);

      // Auto-rearm.
      cfg(64'h55, '1, 1, 1);
      cycle(0, 8'h00, 1, 0, "ar.arm");
      cycle(1, 8'h55, 0, 0, "ar.b0");
      cycle(1, 8'h55, 0, 0, "ar.b1");
      cycle(1, 8'hAA, 0, 0, "ar.b2");
      cycle(1, 8'h55, 0, 0, "ar.b3");
      check_eq("ar.count3", 32'(O_match_count), 32'd3);
      check_eq("ar.armed", 32'(O_armed), 32'd1);

      // Counter saturation.
      cfg(64'h0, 64'h0, 1, 1);
      cycle(0, 8'h00, 1, 0, "sat.arm");
      for (int i = 0; i < CMAX + 5; i++) cycle(1, 8'($urandom), 0, 0, "sat.b");
      check_eq("sat.count", 32'(O_match_count), 32'(CMAX));

      // Out-of-range lengths never match.
      cfg(64'h0, 64'h0, 0, 1);
      cycle(0, 8'h00, 1, 0, "len0.arm");
      for (int i = 0; i < 10; i++) cycle(1, 8'($urandom), 0, 0, "len0.b");
      check_eq("len0.count", 32'(O_match_count), 32'd0);
      cfg(64'h0, 64'h0, 9, 1);
      cycle(0, 8'h00, 1, 0, "len9.arm");
      for (int i = 0; i < 12; i++) cycle(1, 8'($urandom), 0, 0, "len9.b");
      check_eq("len9.count", 32'(O_match_count), 32'd0);

      // Collisions: arm on completing byte, then arm with disarm.
      cfg(64'hA5C30F, '1, 3, 0);
      cycle(0, 8'h00, 1, 0, "co.arm");
      cycle(1, 8'hA5, 0, 0, "co.b0");
      cycle(1, 8'hC3, 0, 0, "co.b1");
      cycle(1, 8'h0F, 1, 0, "co.b2arm");
      check_eq("co.no_pulse", 32'(O_match), 32'd0);
      check_eq("co.armed", 32'(O_armed), 32'd1);
      cycle(0, 8'h00, 1, 1, "co.armdis");
      check_eq("co.idle", 32'(O_armed), 32'd0);

      // Async reset mid-pattern.
      cycle(0, 8'h00, 1, 0, "rs.arm");
      cycle(1, 8'hA5, 0, 0, "rs.b0");
      cycle(1, 8'hC3, 0, 0, "rs.b1");
      reset_n = 1'b0;
      #1;
      outputs_zero("rs.now");
      model_reset();
      m_hold = 1 << 30;
      cycle(1, 8'h0F, 0, 0, "rs.inreset");
      reset_release();
      cycle(0, 8'h00, 0, 0, "rs.s1");
      cycle(0, 8'h00, 0, 0, "rs.s2");
      cycle(1, 8'hA5, 0, 0, "rs.n0");
      cycle(1, 8'hC3, 0, 0, "rs.n1");
      cycle(1, 8'h0F, 0, 0, "rs.n2");
      check_eq("rs.no_match", 32'(O_match), 32'd0);
      cycle(0, 8'h00, 1, 0, "rs.arm2");
      cycle(1, 8'hA5, 0, 0, "rs.m0");
      cycle(1, 8'hC3, 0, 0, "rs.m1");
      cycle(1, 8'h0F, 0, 0, "rs.m2");
      check_eq("rs.match", 32'(O_match), 32'd1);

      // Randomized traffic biased toward the programmed pattern bytes.
      for (int r = 0; r < 12; r++) begin
         len = ($urandom_range(0, 5) == 5) ? (($urandom_range(0, 1) == 0) ? 0 : 9) : int'($urandom_range(1, 4));
         cfg({$urandom, $urandom}, {$urandom, $urandom} | {$urandom, $urandom}, len, 1'($urandom_range(0, 1)));
         cur = (len >= 1 && len <= NB) ? len - 1 : 3;
         for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) d = 8'($urandom);
            else d = I_pattern[8*cur +: 8];
            cur = (cur == 0) ? ((len >= 1 && len <= NB) ? len - 1 : 3) : cur - 1;
            cycle(1'($urandom_range(0, 9) < 7), d,
                  (m_state != 1) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 39) == 0),
                  $urandom_range(0, 59) == 0, "rnd");
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
